// File: rtl/m_net_rx_frame_buf.sv
// Receive frame buffer: hunts lead+SFD, stores NUM payload bytes in a ping-pong RAM, publishes the bank on a good eof.
// o_req/o_err pulse 2 cycles after the deciding cycle; no backpressure, bytes are accepted whenever strobed.
module m_net_rx_frame_buf #(
  parameter logic [7:0]  NUM       = 8'd156,
  parameter logic [3:0]  LEAD_LEN  = 4'd7,
  parameter logic [7:0]  LEAD_BYTE = 8'h55,
  parameter logic [7:0]  SFD_BYTE  = 8'hD5,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_rx_byte_en,
  input  logic [7:0]  im_rx_byte,
  input  logic        i_rx_eof,
  input  logic [7:0]  im_rd_addr,
  output logic [7:0]  om_rd_data,
  output logic        o_req,
  output logic        o_err,
  output logic [15:0] om_frame_cnt,
  output logic [15:0] om_err_cnt
);

  typedef enum logic [1:0] {HUNT, DATA, DONE, DROP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  lead_cnt_q, lead_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  ram_q [0:511];

  always_comb begin
    state_d     = state_q;
    lead_cnt_d  = lead_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    req_d       = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = {wr_bank_q, byte_cnt_q};
    rd_data_d   = ram_q[{rd_bank_q, im_rd_addr}];

    case (state_q)
      HUNT: begin
        gap_cnt_d = '0;
        if (i_rx_byte_en) begin
          if (lead_cnt_q == LEAD_LEN && im_rx_byte == SFD_BYTE) begin
            state_d    = DATA;
            byte_cnt_d = '0;
            lead_cnt_d = '0;
          end else if (im_rx_byte == LEAD_BYTE) begin
            if (lead_cnt_q != LEAD_LEN) lead_cnt_d = lead_cnt_q + 4'd1;
          end else begin
            lead_cnt_d = '0;
          end
        end
        if (i_rx_eof) lead_cnt_d = '0;
      end

      DATA: begin
        // A byte is committed before a coincident eof is judged.
        if (i_rx_byte_en) begin
          gap_cnt_d = '0;
          if (byte_cnt_q == NUM) begin
            state_d = DROP;
          end else begin
            wr_en      = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (i_rx_eof) state_d = (byte_cnt_d == NUM) ? DONE : DROP;
          end
        end else if (i_rx_eof) begin
          state_d = (byte_cnt_q == NUM) ? DONE : DROP;
        end else if (gap_cnt_q == TIMEOUT) begin
          state_d = DROP;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      DONE: begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
        req_d     = 1'b1;
        if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        state_d   = HUNT;
      end

      DROP: begin
        err_d   = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        state_d = HUNT;
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      lead_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      lead_cnt_q  <= lead_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      req_q       <= req_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Payload storage has no reset; contents are only meaningful once published.
  always_ff @(posedge sys_clk) begin
    if (wr_en) ram_q[wr_addr] <= im_rx_byte;
  end

  assign om_rd_data   = rd_data_q;
  assign o_req        = req_q;
  assign o_err        = err_q;
  assign om_frame_cnt = frame_cnt_q;
  assign om_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_net_rx_frame_buf.sv
// Bench for m_net_rx_frame_buf: random byte streams scored against a frame-level reference model.
module tb_m_net_rx_frame_buf;
  localparam int NUM      = 156;
  localparam int LEAD_LEN = 7;
  localparam int TIMEOUT  = 1000;
  localparam logic [7:0] LEAD = 8'h55;
  localparam logic [7:0] SFD  = 8'hD5;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx_byte_en = 1'b0;
  logic [7:0]  im_rx_byte = 8'h00;
  logic        i_rx_eof = 1'b0;
  logic [7:0]  im_rd_addr = 8'h00;
  logic [7:0]  om_rd_data;
  logic        o_req, o_err;
  logic [15:0] om_frame_cnt, om_err_cnt;

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  int err_seen = 0;

  // stream under construction: bytes, idle cycles before each byte, idle cycles before eof (-1 = with last byte)
  logic [7:0] s[$];
  int         g[$];
  int         eof_gap;
  bit         send_eof;
  logic [7:0] rd_a[$];
  logic [7:0] rd_d[$];
  logic [7:0] rb[NUM];
  logic [7:0] pub[NUM];
  bit         pub_vld;
  int         exp_fc, exp_ec;
  int         d_req, d_err, outcome;

  always #10 sys_clk = ~sys_clk;

  m_net_rx_frame_buf dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_rx_byte_en(i_rx_byte_en), .im_rx_byte(im_rx_byte), .i_rx_eof(i_rx_eof),
    .im_rd_addr(im_rd_addr), .om_rd_data(om_rd_data),
    .o_req(o_req), .o_err(o_err),
    .om_frame_cnt(om_frame_cnt), .om_err_cnt(om_err_cnt)
  );

  always @(posedge sys_clk) begin
    if (o_req) req_seen++;
    if (o_err) err_seen++;
  end

  task automatic cyc(input logic en, input logic [7:0] b, input logic eof);
    logic [7:0] a;
    a = 8'($urandom_range(0, NUM - 1));
    i_rx_byte_en = en; im_rx_byte = b; i_rx_eof = eof; im_rd_addr = a;
    @(posedge sys_clk); #1;
    rd_a.push_back(a); rd_d.push_back(om_rd_data);
    i_rx_byte_en = 1'b0; i_rx_eof = 1'b0;
  endtask

  task automatic build(input int nlead, input int npay, input int maxgap, input bit cnt_pay);
    s.delete(); g.delete();
    repeat (nlead) s.push_back(LEAD);
    s.push_back(SFD);
    for (int k = 0; k < npay; k++) begin
      logic [7:0] b;
      b = cnt_pay ? 8'(k) : 8'($urandom);
      if (!cnt_pay && b == LEAD) b = 8'h00;
      s.push_back(b);
    end
    for (int i = 0; i < s.size(); i++) g.push_back(int'($urandom_range(0, maxgap)));
    eof_gap = 0;
    send_eof = 1'b1;
  endtask

  task automatic send();
    rd_a.delete(); rd_d.delete();
    for (int i = 0; i < s.size(); i++) begin
      for (int k = 0; k < g[i]; k++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, s[i], send_eof && eof_gap < 0 && i == s.size() - 1);
    end
    if (send_eof && eof_gap >= 0) begin
      for (int k = 0; k < eof_gap; k++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
    end
  endtask

  // Frame-level reference: find the first SFD preceded by >= LEAD_LEN lead bytes, then judge the payload.
  // outcome: 0 = nothing captured, 1 = good frame, 2 = dropped frame
  task automatic model(output int oc, output int start);
    int run;
    int mg;
    run = 0; start = -1; oc = 0;
    for (int i = 0; i < s.size(); i++) begin
      if (start < 0) begin
        if (s[i] == SFD && run >= LEAD_LEN) start = i + 1;
        else if (s[i] == LEAD) run++;
        else run = 0;
      end
    end
    if (start >= 0) begin
      mg = (eof_gap > 0) ? eof_gap : 0;
      for (int i = start; i < s.size(); i++) if (g[i] > mg) mg = g[i];
      oc = (s.size() - start == NUM && mg <= TIMEOUT) ? 1 : 2;
    end
  endtask

  task automatic run_frame();
    int r0, e0, start;
    r0 = req_seen; e0 = err_seen;
    send();
    repeat (4) @(posedge sys_clk);
    #1;
    d_req = req_seen - r0;
    d_err = err_seen - e0;
    model(outcome, start);
    if (outcome == 1) begin
      if (exp_fc < 65535) exp_fc++;
      for (int k = 0; k < NUM; k++) pub[k] = s[start + k];
      pub_vld = 1'b1;
    end else if (outcome == 2) begin
      if (exp_ec < 65535) exp_ec++;
    end
  endtask

  task automatic readback();
    for (int a = 0; a < NUM; a++) begin
      im_rd_addr = 8'(a);
      @(posedge sys_clk); #1;
      rb[a] = om_rd_data;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    exp_fc = 0; exp_ec = 0; pub_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({o_req, o_err, om_rd_data, om_frame_cnt, om_err_cnt} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {o_req, o_err, om_rd_data, om_frame_cnt, om_err_cnt});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if ({o_req, o_err, om_frame_cnt, om_err_cnt} !== 34'd0) begin
      errors++;
      $display("FAIL reset_idle got %h want 0", {o_req, o_err, om_frame_cnt, om_err_cnt});
    end
    exp_fc = 0; exp_ec = 0; pub_vld = 1'b0;
  endtask

  task automatic test_basic();
    int bad, first;
    do_reset();
    build(LEAD_LEN, NUM, 0, 1'b1);
    send();
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL t1_req_early got %b want 0", o_req); end
    @(posedge sys_clk); #1;
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL t1_req_2clk got %b want 1", o_req); end
    checks++;
    if (om_frame_cnt !== 16'd1) begin errors++; $display("FAIL t1_frame_cnt got %0d want 1", om_frame_cnt); end
    @(posedge sys_clk); #1;
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL t1_req_width got %b want 0", o_req); end
    checks++;
    if (om_err_cnt !== 16'd0) begin errors++; $display("FAIL t1_err_cnt got %0d want 0", om_err_cnt); end
    readback();
    bad = 0; first = -1;
    for (int a = 0; a < NUM; a++) if (rb[a] !== 8'(a)) begin bad++; if (first < 0) first = a; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t1_readback %0d bad, addr %0d got %h want %h", bad, first, rb[first], 8'(first)); end
  endtask

  task automatic test_pingpong();
    logic [7:0] a_copy[NUM];
    int bad;
    do_reset();
    build(LEAD_LEN, NUM, 0, 1'b0);
    run_frame();
    for (int k = 0; k < NUM; k++) a_copy[k] = pub[k];
    build(LEAD_LEN, NUM, 2, 1'b0);
    run_frame();
    bad = 0;
    for (int i = 0; i < rd_a.size(); i++) if (rd_d[i] !== a_copy[rd_a[i]]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t2_read_during got %0d stale reads want 0", bad); end
    checks++;
    if (d_req !== 1 || om_frame_cnt !== 16'(exp_fc)) begin
      errors++; $display("FAIL t2_req got pulses %0d cnt %0d want 1 %0d", d_req, om_frame_cnt, exp_fc);
    end
    readback();
    bad = 0;
    for (int a = 0; a < NUM; a++) if (rb[a] !== pub[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t2_readback_b got %0d bad want 0", bad); end
  endtask

  task automatic test_length();
    int bad;
    do_reset();
    build(LEAD_LEN, NUM, 1, 1'b0);
    run_frame();
    for (int n = NUM - 1; n <= NUM + 1; n += 2) begin
      build(LEAD_LEN, n, 1, 1'b0);
      run_frame();
      checks++;
      if (d_err !== 1 || d_req !== 0) begin
        errors++; $display("FAIL t3_len%0d got err %0d req %0d want 1 0", n, d_err, d_req);
      end
      checks++;
      if (om_err_cnt !== 16'(exp_ec) || om_frame_cnt !== 16'(exp_fc)) begin
        errors++; $display("FAIL t3_cnts_len%0d got %0d %0d want %0d %0d", n, om_err_cnt, om_frame_cnt, exp_ec, exp_fc);
      end
      readback();
      bad = 0;
      for (int a = 0; a < NUM; a++) if (rb[a] !== pub[a]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL t3_prev_kept_len%0d got %0d bad want 0", n, bad); end
    end
  endtask

  task automatic test_hunt();
    int bad;
    do_reset();
    build(LEAD_LEN - 1, NUM, 0, 1'b0);
    run_frame();
    checks++;
    if (d_req !== 0 || d_err !== 0 || om_frame_cnt !== 16'd0 || om_err_cnt !== 16'd0) begin
      errors++; $display("FAIL t4_short_lead got req %0d err %0d cnts %0d %0d want 0 0 0 0", d_req, d_err, om_frame_cnt, om_err_cnt);
    end
    build(LEAD_LEN, NUM, 0, 1'b0);
    s.push_front(8'hAA); g.push_front(0);
    repeat (LEAD_LEN) begin s.push_front(LEAD); g.push_front(0); end
    run_frame();
    checks++;
    if (d_req !== 1 || d_err !== 0 || outcome !== 1) begin
      errors++; $display("FAIL t4_restart got req %0d err %0d want 1 0", d_req, d_err);
    end
    readback();
    bad = 0;
    for (int a = 0; a < NUM; a++) if (rb[a] !== pub[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t4_readback got %0d bad want 0", bad); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int stall = TIMEOUT + 1; stall >= TIMEOUT; stall--) begin
      build(LEAD_LEN, NUM, 0, 1'b0);
      g[LEAD_LEN + 1 + 81] = stall;
      run_frame();
      checks++;
      if (d_req !== ((outcome == 1) ? 1 : 0) || d_err !== ((outcome == 2) ? 1 : 0)) begin
        errors++; $display("FAIL t5_stall%0d got req %0d err %0d want %0d %0d", stall, d_req, d_err, (outcome == 1), (outcome == 2));
      end
      checks++;
      if (om_frame_cnt !== 16'(exp_fc) || om_err_cnt !== 16'(exp_ec)) begin
        errors++; $display("FAIL t5_cnts%0d got %0d %0d want %0d %0d", stall, om_frame_cnt, om_err_cnt, exp_fc, exp_ec);
      end
    end
  endtask

  task automatic test_midreset();
    int e0, bad;
    do_reset();
    build(LEAD_LEN, NUM, 1, 1'b0);
    while (s.size() > LEAD_LEN + 1 + 100) begin void'(s.pop_back()); void'(g.pop_back()); end
    send_eof = 1'b0;
    e0 = err_seen;
    send();
    do_reset();
    repeat (4) @(posedge sys_clk);
    #1;
    checks++;
    if (err_seen != e0 || om_err_cnt !== 16'd0 || om_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL t6_after_rst got errs %0d cnts %0d %0d want 0 0 0", err_seen - e0, om_err_cnt, om_frame_cnt);
    end
    build(LEAD_LEN, NUM, 1, 1'b0);
    run_frame();
    checks++;
    if (d_req !== 1 || om_frame_cnt !== 16'd1 || om_err_cnt !== 16'd0) begin
      errors++; $display("FAIL t6_good got req %0d cnts %0d %0d want 1 1 0", d_req, om_frame_cnt, om_err_cnt);
    end
    readback();
    bad = 0;
    for (int a = 0; a < NUM; a++) if (rb[a] !== pub[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL t6_readback got %0d bad want 0", bad); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      int nl, np;
      nl = int'($urandom_range(LEAD_LEN - 1, LEAD_LEN + 2));
      case ($urandom_range(0, 3))
        0: np = NUM - 1;
        1: np = NUM + 1;
        default: np = NUM;
      endcase
      build(nl, np, 2, 1'b0);
      eof_gap = int'($urandom_range(0, 3)) - 1;
      if ($urandom_range(0, 3) == 0) begin
        s.push_front(8'h12); g.push_front(0);
        s.push_front(LEAD); g.push_front(0);
      end
      run_frame();
      checks++;
      if (d_req !== ((outcome == 1) ? 1 : 0) || d_err !== ((outcome == 2) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_pulses got req %0d err %0d want %0d %0d", it, d_req, d_err, (outcome == 1), (outcome == 2));
      end
      checks++;
      if (om_frame_cnt !== 16'(exp_fc) || om_err_cnt !== 16'(exp_ec)) begin
        errors++; $display("FAIL rnd%0d_cnts got %0d %0d want %0d %0d", it, om_frame_cnt, om_err_cnt, exp_fc, exp_ec);
      end
      if (pub_vld) begin
        readback();
        bad = 0;
        for (int a = 0; a < NUM; a++) if (rb[a] !== pub[a]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rnd%0d_readback got %0d bad want 0", it, bad); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pingpong();
    test_length();
    test_hunt();
    test_timeout();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
